// File: rtl/regfile_pkg.sv
// Shared register-file definitions: default widths, the hardwired-zero
// register index and the write-command record used by writeback logic.
package regfile_pkg;

    localparam int AW_DEFAULT = 5;
    localparam int DW_DEFAULT = 32;

    // Register 0 reads as zero, so writes aimed at it are dropped.
    localparam logic [AW_DEFAULT-1:0] REG_ZERO = '0;

    // One write request or command toward the register file.
    typedef struct packed {
        logic                  valid;
        logic [AW_DEFAULT-1:0] addr;
        logic [DW_DEFAULT-1:0] data;
    } wr_cmd_t;

    // Returns 1 when an address names a real, writable register.
    function automatic logic is_writable(input logic [AW_DEFAULT-1:0] addr);
        return addr != REG_ZERO;
    endfunction

endpackage

// File: rtl/regwrite_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. The pointer remembers the most recently
// granted requester so that on a tie the other requester wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    // Grant selection: a lone requester always wins, and a tie goes to the one not granted last.
    always_comb begin
        gnt_o = 2'b00;
        if (rst_n) begin
            unique case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
        end
    end

    // Pointer follows the granted index and holds while nobody is granted.
    always_comb begin
        last_d = last_q;
        if (gnt_o[0]) begin
            last_d = 1'b0;
        end else if (gnt_o[1]) begin
            last_d = 1'b1;
        end
    end

    // Pointer register; reset points at requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/regwrite_arbiter.sv
// Shares the register file's single write port between the MEM/WB stage
// (requester 0) and the load/debug unit (requester 1). The granted request
// is registered into a one-cycle write command; writes to register 0 are
// acknowledged but dropped, committed writes are counted, and a read of the
// register being written this cycle is flagged.
module regwrite_arbiter
    import regfile_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          req0_valid,
    input  logic [AW-1:0] req0_reg,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,

    input  logic          req1_valid,
    input  logic [AW-1:0] req1_reg,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,

    output logic          regwrite,
    output logic [AW-1:0] writereg,
    output logic [DW-1:0] writeda,

    input  logic [AW-1:0] rd_addr,
    output logic          pend_hit,
    output logic [CW-1:0] wr_count
);

    localparam logic [CW-1:0] COUNT_MAX = '1;
    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    logic [1:0]    gnt;
    cmd_t          selCmd;
    logic          selWritable;

    logic          regwrite_q, regwrite_d;
    logic [AW-1:0] writereg_q, writereg_d;
    logic [DW-1:0] writeda_q,  writeda_d;
    logic [CW-1:0] wr_count_q, wr_count_d;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i ({req1_valid, req0_valid}),
        .gnt_o (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    // Request mux: pick the granted requester's address and data.
    always_comb begin
        selCmd       = '0;
        selCmd.valid = |gnt;
        if (gnt[1]) begin
            selCmd.addr = req1_reg;
            selCmd.data = req1_data;
        end else begin
            selCmd.addr = req0_reg;
            selCmd.data = req0_data;
        end
        selWritable = selCmd.valid && (selCmd.addr != ZERO_ADDR);
    end

    // Next write command: load on a real write, otherwise drop the strobe and hold address/data.
    always_comb begin
        regwrite_d = 1'b0;
        writereg_d = writereg_q;
        writeda_d  = writeda_q;
        wr_count_d = wr_count_q;
        if (selWritable) begin
            regwrite_d = 1'b1;
            writereg_d = selCmd.addr;
            writeda_d  = selCmd.data;
            if (wr_count_q != COUNT_MAX) begin
                wr_count_d = wr_count_q + 1'b1;
            end
        end
    end

    // Output command register and committed-write counter; reset cancels any in-flight write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regwrite_q <= 1'b0;
            writereg_q <= '0;
            writeda_q  <= '0;
            wr_count_q <= '0;
        end else begin
            regwrite_q <= regwrite_d;
            writereg_q <= writereg_d;
            writeda_q  <= writeda_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign regwrite = regwrite_q;
    assign writereg = writereg_q;
    assign writeda  = writeda_q;
    assign wr_count = wr_count_q;

    // Hazard flag: decode is reading the register that commits on this cycle's falling edge.
    always_comb begin
        pend_hit = regwrite_q && (writereg_q == rd_addr) && (rd_addr != ZERO_ADDR);
    end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Directed self-checking bench for regwrite_arbiter: a table of per-cycle
// vectors followed by hand-written reset and counter-saturation sequences.
module tb_regwrite_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk;
    logic          rstN;
    logic          req0Valid, req1Valid;
    logic [AW-1:0] req0Reg, req1Reg;
    logic [DW-1:0] req0Data, req1Data;
    logic          req0Ready, req1Ready;
    logic          regWrite;
    logic [AW-1:0] writeReg;
    logic [DW-1:0] writeDa;
    logic [AW-1:0] rdAddr;
    logic          pendHit;
    logic [CW-1:0] wrCount;

    int testsRun;
    int testsFailed;

    typedef struct {
        logic          rstN;
        logic          v0;
        logic [AW-1:0] r0;
        logic [DW-1:0] d0;
        logic          v1;
        logic [AW-1:0] r1;
        logic [DW-1:0] d1;
        logic [AW-1:0] rd;
        logic          expRdy0;
        logic          expRdy1;
        logic          expPend;
        logic          expRw;
        logic [AW-1:0] expWr;
        logic [DW-1:0] expWd;
        logic [CW-1:0] expCnt;
    } vec_t;

    vec_t tbl[13];

    regwrite_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rstN),
        .req0_valid (req0Valid),
        .req0_reg   (req0Reg),
        .req0_data  (req0Data),
        .req0_ready (req0Ready),
        .req1_valid (req1Valid),
        .req1_reg   (req1Reg),
        .req1_data  (req1Data),
        .req1_ready (req1Ready),
        .regwrite   (regWrite),
        .writereg   (writeReg),
        .writeda    (writeDa),
        .rd_addr    (rdAddr),
        .pend_hit   (pendHit),
        .wr_count   (wrCount)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic v0, input logic [AW-1:0] r0, input logic [DW-1:0] d0,
                                 input logic v1, input logic [AW-1:0] r1, input logic [DW-1:0] d1,
                                 input logic [AW-1:0] rd);
        rstN      = rst;
        req0Valid = v0;
        req0Reg   = r0;
        req0Data  = d0;
        req1Valid = v1;
        req1Reg   = r1;
        req1Data  = d1;
        rdAddr    = rd;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0);

        //          rst v0 r0  d0     v1 r1  d1     rd   rdy0 rdy1 pend  rw wr  wd     cnt
        tbl[0]  = '{0, 1, 3, 32'h5,  0, 0, 32'h0,  0,   0,   0,   0,    0, 0, 32'h0,  0};
        tbl[1]  = '{1, 1, 3, 32'h5,  0, 0, 32'h0,  3,   1,   0,   0,    1, 3, 32'h5,  1};
        tbl[2]  = '{1, 0, 0, 32'h0,  0, 0, 32'h0,  3,   0,   0,   1,    0, 3, 32'h5,  1};
        tbl[3]  = '{1, 1, 1, 32'hA,  1, 2, 32'hB,  0,   0,   1,   0,    1, 2, 32'hB,  2};
        tbl[4]  = '{1, 1, 1, 32'hA,  1, 2, 32'hB,  2,   1,   0,   1,    1, 1, 32'hA,  3};
        tbl[5]  = '{1, 1, 1, 32'hA,  1, 2, 32'hB,  1,   0,   1,   1,    1, 2, 32'hB,  4};
        tbl[6]  = '{1, 1, 1, 32'hA,  1, 2, 32'hB,  1,   1,   0,   0,    1, 1, 32'hA,  5};
        tbl[7]  = '{1, 0, 0, 32'h0,  1, 0, 32'hFF, 0,   0,   1,   0,    0, 1, 32'hA,  5};
        tbl[8]  = '{1, 1, 4, 32'h44, 1, 6, 32'h66, 1,   1,   0,   0,    1, 4, 32'h44, 6};
        tbl[9]  = '{1, 0, 0, 32'h0,  1, 6, 32'h66, 4,   0,   1,   1,    1, 6, 32'h66, 7};
        tbl[10] = '{1, 1, 5, 32'h55, 0, 0, 32'h0,  6,   1,   0,   1,    1, 5, 32'h55, 8};
        tbl[11] = '{1, 0, 0, 32'h0,  0, 0, 32'h0,  6,   0,   0,   0,    0, 5, 32'h55, 8};
        tbl[12] = '{1, 0, 0, 32'h0,  0, 0, 32'h0,  5,   0,   0,   0,    0, 5, 32'h55, 8};

        // Hold reset across one edge so the table starts from a known state.
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i].rstN, tbl[i].v0, tbl[i].r0, tbl[i].d0,
                          tbl[i].v1, tbl[i].r1, tbl[i].d1, tbl[i].rd);
            #1;
            checkOutput($sformatf("vec%0d req0_ready", i), 64'(req0Ready), 64'(tbl[i].expRdy0));
            checkOutput($sformatf("vec%0d req1_ready", i), 64'(req1Ready), 64'(tbl[i].expRdy1));
            checkOutput($sformatf("vec%0d pend_hit", i),   64'(pendHit),   64'(tbl[i].expPend));
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("vec%0d regwrite", i), 64'(regWrite), 64'(tbl[i].expRw));
            checkOutput($sformatf("vec%0d writereg", i), 64'(writeReg), 64'(tbl[i].expWr));
            checkOutput($sformatf("vec%0d writeda", i),  64'(writeDa),  64'(tbl[i].expWd));
            checkOutput($sformatf("vec%0d wr_count", i), 64'(wrCount),  64'(tbl[i].expCnt));
        end

        // Reset mid-operation: put a write in flight, then reset while req1 waits.
        applyStimulus(1'b1, 1'b1, 5'd7, 32'h77, 1'b0, '0, '0, 5'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("inflight regwrite", 64'(regWrite), 64'd1);
        checkOutput("inflight writereg", 64'(writeReg), 64'd7);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 5'd9, 32'h99, 5'd7);
        #1;
        checkOutput("rst req0_ready", 64'(req0Ready), 64'd0);
        checkOutput("rst req1_ready", 64'(req1Ready), 64'd0);
        checkOutput("rst pend_hit before edge", 64'(pendHit), 64'd1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst regwrite", 64'(regWrite), 64'd0);
        checkOutput("rst writereg", 64'(writeReg), 64'd0);
        checkOutput("rst writeda",  64'(writeDa),  64'd0);
        checkOutput("rst wr_count", 64'(wrCount),  64'd0);
        checkOutput("rst pend_hit", 64'(pendHit),  64'd0);
        rstN = 1'b1;
        #1;
        checkOutput("post-rst req1_ready", 64'(req1Ready), 64'd1);
        checkOutput("post-rst req0_ready", 64'(req0Ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("post-rst regwrite", 64'(regWrite), 64'd1);
        checkOutput("post-rst writereg", 64'(writeReg), 64'd9);
        checkOutput("post-rst writeda",  64'(writeDa),  64'h99);
        checkOutput("post-rst wr_count", 64'(wrCount),  64'd1);

        // Counter saturation: reset, then stream writes up to 2^CW-2 and three more.
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("sat start wr_count", 64'(wrCount), 64'd0);
        applyStimulus(1'b1, 1'b1, 5'd1, 32'h1, 1'b0, '0, '0, '0);
        repeat (65534) @(posedge clk);
        @(negedge clk);
        checkOutput("sat preload wr_count", 64'(wrCount), 64'hFFFE);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("sat wr_count", 64'(wrCount), 64'hFFFF);
        checkOutput("sat regwrite", 64'(regWrite), 64'd1);
        req0Valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
